uart_io_tx: RTL and testbench

//  Memory-mapped UART transmitter: the CPU-to-PC direction of the serial link that uart_bmpg uses to receive programs.
//  CPU stores (ioWrite + UartCtrl chip select from MemOrIO) push bytes into a small FIFO.
//  An 8N1 serialiser drains the FIFO onto tx. A status word is readable via ioRead.

---
 rtl/uart_io_tx_pkg.sv | 32 +++
 rtl/uart_io_tx_if.sv | 29 ++
 rtl/uart_io_tx_fifo.sv | 59 +++++
 rtl/uart_io_tx.sv | 148 ++++++++++++++
 tb/tb_uart_io_tx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_io_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, STATUS bit positions and FSM state encodings.
// The same constants drive the UartCtrl address decode in MemOrIO.
package uart_io_tx_pkg;

  // Register offsets (addr_out[1:0])
  localparam logic [1:0] UART_DATA_OFS = 2'b00;
  localparam logic [1:0] UART_STAT_OFS = 2'b10;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // Serialiser FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Assemble the 16-bit STATUS word; the upper byte always reads 0.
  function automatic logic [15:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] cnt);
    pack_status = {8'h00, cnt, ovf, empty, full, busy};
  endfunction

endpackage

// File: rtl/uart_io_tx_if.sv
// IO-bus view of the UART transmitter.
//   uartcs        : chip select (UartCtrl from MemOrIO)
//   uartwrite     : ioWrite strobe
//   uartread      : ioRead strobe
//   uartaddr      : register offset
//   uartinputdata : store data
//   uart_rdata    : status read data (combinational)
// Handshake: every access is a single-cycle strobe with no ready/backpressure.
// A write is taken on the clock edge where uartcs&uartwrite is high; a DATA
// write that meets a full FIFO is dropped and flagged in STATUS.overflow.
// Reads are combinational and side-effect free.
interface uart_io_tx_if;
  logic        uartcs;
  logic        uartwrite;
  logic        uartread;
  logic [1:0]  uartaddr;
  logic [15:0] uartinputdata;
  logic [15:0] uart_rdata;

  modport master (
    output uartcs, uartwrite, uartread, uartaddr, uartinputdata,
    input  uart_rdata
  );

  modport slave (
    input  uartcs, uartwrite, uartread, uartaddr, uartinputdata,
    output uart_rdata
  );
endinterface

// File: rtl/uart_io_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i, din_i: enqueue (ignored when full)
//   pop_i        : dequeue (ignored when empty)
//   dout_o       : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // full is the pre-edge value, so a push on a full FIFO is dropped even if
  // a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_tx.sv
// uart_io_tx: memory-mapped 8N1 UART transmitter (CPU -> PC direction).
//   uartclk, uartrst : clock, synchronous active-high reset
//   bus              : IO-bus slave (DATA write at offset 0, STATUS at offset 2)
//   tx               : registered serial line, idle high
//   dbg_state_o      : current serialiser FSM state
// CPU stores are queued in a FIFO; the serialiser drains it one frame at a
// time: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
module uart_io_tx
  import uart_io_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 23_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         uartclk,
  input  logic         uartrst,
  uart_io_tx_if.slave  bus,
  output logic         tx,
  output logic [1:0]   dbg_state_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             wr_data, wr_stat, rd_stat;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [AW:0]      fifo_count;
  logic             baud_done;
  logic [15:0]      status;
  logic             unused_hi_data;

  // Register decode
  assign wr_data = bus.uartcs && bus.uartwrite && (bus.uartaddr == UART_DATA_OFS);
  assign wr_stat = bus.uartcs && bus.uartwrite && (bus.uartaddr == UART_STAT_OFS);
  assign rd_stat = bus.uartcs && bus.uartread  && (bus.uartaddr == UART_STAT_OFS);
  assign unused_hi_data = ^bus.uartinputdata[15:8];

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (uartclk),
    .rst_i   (uartrst),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .din_i   (bus.uartinputdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_done = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is the registered image of the current state, so the line trails the
  // FSM by one clock but every bit still lasts exactly CLKS_PER_BIT clocks.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Clear first so a same-edge overflow still sets the flag.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat && bus.uartinputdata[STAT_OVF]) ovf_d = 1'b0;
    if (wr_data && fifo_full)                   ovf_d = 1'b1;
  end

  always_ff @(posedge uartclk) begin
    if (uartrst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign status = pack_status(state_q != ST_IDLE, fifo_full, fifo_empty, ovf_q,
                              4'(fifo_count));
  assign bus.uart_rdata = rd_stat ? status : 16'h0000;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_io_tx.sv
// Bench for uart_io_tx at 10 clocks per bit (100 clocks per frame).
// A line receiver watching tx decodes frames into rx_q, sampling 2% fast;
// bytes accepted by the FIFO are predicted into exp_q and compared in order.
module tb_uart_io_tx;
  import uart_io_tx_pkg::*;

  localparam int CPB = 10;
  localparam int RX_HALF = 49;  // receiver half bit, about 2% fast
  localparam int RX_BIT  = 98;  // receiver full bit, about 2% fast

  logic       clk;
  logic       rst;
  logic       tx;
  logic [1:0] dbg_state;

  uart_io_tx_if bus_if ();

  uart_io_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
    .uartclk     (clk),
    .uartrst     (rst),
    .bus         (bus_if),
    .tx          (tx),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_err = 0;
  logic [7:0] rx_byte;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line receiver: mid-bit sampling from the start-bit falling edge.
  initial begin
    forever begin
      @(negedge tx);
      #(RX_HALF);
      if (tx !== 1'b0) rx_err++;
      for (int i = 0; i < 8; i++) begin
        #(RX_BIT);
        rx_byte[i] = tx;
      end
      #(RX_BIT);
      if (tx !== 1'b1) rx_err++;
      rx_q.push_back(rx_byte);
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic cpu_write(input logic [1:0] addr, input logic [15:0] data);
    bus_if.uartcs        = 1'b1;
    bus_if.uartwrite     = 1'b1;
    bus_if.uartaddr      = addr;
    bus_if.uartinputdata = data;
    @(posedge clk);
    @(negedge clk);
    bus_if.uartcs        = 1'b0;
    bus_if.uartwrite     = 1'b0;
    bus_if.uartaddr      = 2'b00;
    bus_if.uartinputdata = 16'h0000;
  endtask

  task automatic cpu_read(input logic [1:0] addr, input logic cs, output logic [15:0] v);
    bus_if.uartcs   = cs;
    bus_if.uartread = 1'b1;
    bus_if.uartaddr = addr;
    #1;
    v = bus_if.uart_rdata;
    bus_if.uartcs   = 1'b0;
    bus_if.uartread = 1'b0;
    bus_if.uartaddr = 2'b00;
  endtask

  task automatic test_reset();
    logic [15:0] st;
    bus_if.uartcs = 1'b0; bus_if.uartwrite = 1'b0; bus_if.uartread = 1'b0;
    bus_if.uartaddr = 2'b00; bus_if.uartinputdata = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cpu_write(UART_DATA_OFS, 16'h00AA);  // ignored while in reset
    rst = 1'b0;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0004) begin bad++; $display("FAIL rst_status got=%h exp=0004", st); end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    repeat (150) @(negedge clk);
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL rst_no_frame got=%0d exp=0", rx_q.size()); end
  endtask

  task automatic test_single();
    logic [9:0]  frame;
    logic [15:0] st;
    frame = {1'b1, 8'h55, 1'b0};
    cpu_write(UART_DATA_OFS, 16'h0055);  // captured at edge E, now after E
    exp_q.push_back(8'h55);
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL t1_prestart got=%b exp=1", tx); end
      end else if (k == 2) begin
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL t1_fall got=%b exp=0", tx); end
      end else if (k < 102 && ((k - 2) % CPB) == 5) begin
        total++;
        if (tx !== frame[(k - 2) / CPB])
          begin bad++; $display("FAIL t1_bit%0d got=%b exp=%b", (k - 2) / CPB, tx, frame[(k - 2) / CPB]); end
      end
    end
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL t1_idle got=%b exp=1", tx); end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0004) begin bad++; $display("FAIL t1_status got=%h exp=0004", st); end
    total++;
    if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL t1_rx_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL t1_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] st;
    logic [7:0]  bytes [3];
    bytes[0] = 8'hA3; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cpu_write(UART_DATA_OFS, {8'h00, bytes[i]});
      exp_q.push_back(bytes[i]);
    end
    // now just after E+2: one byte in flight, two queued
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0021) begin bad++; $display("FAIL t2_status_e2 got=%h exp=0021", st); end
    for (int k = 3; k <= 103; k++) begin
      @(negedge clk);
      if (k == 101) begin
        cpu_read(UART_STAT_OFS, 1'b1, st);
        total++;
        if (st !== 16'h0020) begin bad++; $display("FAIL t2_gap_status got=%h exp=0020", st); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL t2_gap_tx got=%b exp=1", tx); end
      end else if (k == 102) begin
        cpu_read(UART_STAT_OFS, 1'b1, st);
        total++;
        if (st !== 16'h0011) begin bad++; $display("FAIL t2_pop_status got=%h exp=0011", st); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL t2_idle_gap_tx got=%b exp=1", tx); end
      end else if (k == 103) begin
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL t2_second_start got=%b exp=0", tx); end
      end
    end
    for (int i = 0; i < 400 && rx_q.size() < 3; i++) @(negedge clk);
    total++;
    if (rx_q.size() != 3) begin bad++; $display("FAIL t2_rx_count got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL t2_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    repeat (20) @(negedge clk);
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [15:0] st;
    logic [7:0]  b;
    // One byte leaves for the serialiser, eight fill the FIFO, the tenth is lost.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      cpu_write(UART_DATA_OFS, {8'h00, b});
      if (i < 9) exp_q.push_back(b);
    end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h008B) begin bad++; $display("FAIL t3_full_ovf got=%h exp=008b", st); end
    cpu_write(UART_STAT_OFS, 16'h0008);
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0083) begin bad++; $display("FAIL t3_ovf_clear got=%h exp=0083", st); end
    for (int i = 0; i < 1200 && rx_q.size() < 9; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++;
    if (rx_q.size() != 9) begin bad++; $display("FAIL t3_rx_count got=%0d exp=9", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL t3_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0004) begin bad++; $display("FAIL t3_drained got=%h exp=0004", st); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_frame_reset();
    logic [15:0] st;
    int lows;
    for (int i = 0; i < 3; i++) cpu_write(UART_DATA_OFS, 16'(i + 16'h0031));
    repeat (43) @(negedge clk);  // after E+45
    rst = 1'b1;
    bus_if.uartcs = 1'b1; bus_if.uartwrite = 1'b1;
    bus_if.uartaddr = UART_DATA_OFS; bus_if.uartinputdata = 16'h0077;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_if.uartcs = 1'b0; bus_if.uartwrite = 1'b0; bus_if.uartinputdata = 16'h0000;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL t4_tx got=%b exp=1", tx); end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0004) begin bad++; $display("FAIL t4_status got=%h exp=0004", st); end
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin bad++; $display("FAIL t4_silent got=%0d exp=0", lows); end
    rx_q.delete(); exp_q.delete();
    rx_err = 0;
  endtask

  task automatic test_push_pop_same_edge();
    logic [15:0] st;
    logic [7:0]  b;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      cpu_write(UART_DATA_OFS, {8'h00, b});
      exp_q.push_back(b);
    end
    cpu_read(UART_STAT_OFS, 1'b1, st);  // after E+1
    total++;
    if (st !== 16'h0011) begin bad++; $display("FAIL t5_queued got=%h exp=0011", st); end
    repeat (100) @(negedge clk);       // after E+101: idle gap, one byte waiting
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0010) begin bad++; $display("FAIL t5_gap got=%h exp=0010", st); end
    b = 8'($urandom_range(0, 255));
    cpu_write(UART_DATA_OFS, {8'h00, b});  // push on the pop edge E+102
    exp_q.push_back(b);
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0011) begin bad++; $display("FAIL t5_same_edge got=%h exp=0011", st); end
    cpu_read(2'b01, 1'b1, st);
    total++;
    if (st !== 16'h0000) begin bad++; $display("FAIL t5_rd_ofs1 got=%h exp=0000", st); end
    cpu_read(2'b11, 1'b1, st);
    total++;
    if (st !== 16'h0000) begin bad++; $display("FAIL t5_rd_ofs3 got=%h exp=0000", st); end
    cpu_read(UART_DATA_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0000) begin bad++; $display("FAIL t5_rd_ofs0 got=%h exp=0000", st); end
    cpu_read(UART_STAT_OFS, 1'b0, st);
    total++;
    if (st !== 16'h0000) begin bad++; $display("FAIL t5_rd_nocs got=%h exp=0000", st); end
    for (int i = 0; i < 400 && rx_q.size() < 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++;
    if (rx_q.size() != 3) begin bad++; $display("FAIL t5_rx_count got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL t5_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_loopback();
    logic [15:0] st;
    logic [7:0]  b;
    int sent, guard, n;
    sent = 0;
    guard = 0;
    while (sent < 256 && guard < 40000) begin
      cpu_read(UART_STAT_OFS, 1'b1, st);
      if (!st[STAT_FULL]) begin
        b = 8'($urandom_range(0, 255));
        cpu_write(UART_DATA_OFS, {8'h00, b});
        exp_q.push_back(b);
        sent++;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    total++;
    if (sent != 256) begin bad++; $display("FAIL t6_sent got=%0d exp=256", sent); end
    for (int i = 0; i < 30000 && rx_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n = exp_q.size();
    total++;
    if (rx_q.size() != n) begin bad++; $display("FAIL t6_rx_count got=%0d exp=%0d", rx_q.size(), n); end
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL t6_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    total++;
    if (rx_err != 0) begin bad++; $display("FAIL t6_framing got=%0d exp=0", rx_err); end
    cpu_read(UART_STAT_OFS, 1'b1, st);
    total++;
    if (st !== 16'h0004) begin bad++; $display("FAIL t6_final_status got=%h exp=0004", st); end
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mid_frame_reset();
    test_push_pop_same_edge();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
